// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_if : two-requester operation bus + response bus              |
// | Optional: ALU_ZERO_FLAG_EN adds rsp_zero.   Rev 1.0                      |
// +--------------------------------------------------------------------------+
interface alu_arbiter_if;
   logic       req0_valid;
   logic       req1_valid;
   logic       req0_ready;
   logic       req1_ready;
   logic [2:0] req0_op;
   logic [2:0] req1_op;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_data;
`ifdef ALU_ZERO_FLAG_EN
   logic       rsp_zero;
`endif
   logic       busy;

   modport master (
      output req0_valid, req1_valid, req0_op, req1_op,
             req0_a, req0_b, req1_a, req1_b, rsp_ready,
`ifdef ALU_ZERO_FLAG_EN
      input  rsp_zero,
`endif
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  req0_valid, req1_valid, req0_op, req1_op,
             req0_a, req0_b, req1_a, req1_b, rsp_ready,
`ifdef ALU_ZERO_FLAG_EN
      output rsp_zero,
`endif
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter : round-robin arbiter for two requesters sharing a 4-bit ALU |
// | Optional: ALU_ZERO_FLAG_EN adds rsp_zero.   Rev 1.0                      |
// +--------------------------------------------------------------------------+

module alu4 (
   input  wire  [3:0] A,
   input  wire  [3:0] B,
   input  wire        L,
   input  wire        M,
   input  wire        N,
   output logic [3:0] S
);
   always_comb begin
      S = 4'd0;
      case ({L, M, N})
         3'b000: S = 4'd0 - A;
         3'b001: S = 4'd0 - B;
         3'b010: S = A + B;
         3'b011: S = A - B;
         3'b100: S = A & B;
         3'b101: S = A | B;
         3'b110: S = A * B;   // 4-bit context keeps only the low nibble
         3'b111: S = A ^ B;
         default: S = 4'd0;
      endcase
   end
endmodule

module alu_arbiter (
   input wire           clk,
   input wire           rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_any_valid;
   logic       w_gnt_id;
   logic       w_accept;
   logic       w_exec;
   logic       w_rsp_hs;
   logic       w_ready0;
   logic       w_ready1;
   logic [3:0] w_alu_s;
   logic [2:0] r_op;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_gnt_id;
   logic       r_last_grant;
   logic       r_rsp_valid;
   logic       r_rsp_id;
   logic [3:0] r_rsp_data;
`ifdef ALU_ZERO_FLAG_EN
   logic       r_rsp_zero;
`endif

   // On a tie the requester not served last wins; a lone requester always wins.
   assign w_any_valid = bus.req0_valid | bus.req1_valid;
   assign w_gnt_id    = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      w_rsp_hs    = 1'b0;
      w_ready0    = 1'b0;
      w_ready1    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_valid) begin
               w_accept    = 1'b1;
               w_ready0    = ~w_gnt_id;
               w_ready1    = w_gnt_id;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_exec      = 1'b1;
            w_state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_hs    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   alu4 u_alu (
      .S (w_alu_s),
      .A (r_a),
      .B (r_b),
      .L (r_op[2]),
      .M (r_op[1]),
      .N (r_op[0])
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op         <= 3'd0;
         r_a          <= 4'd0;
         r_b          <= 4'd0;
         r_gnt_id     <= 1'b0;
         r_last_grant <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= 4'd0;
`ifdef ALU_ZERO_FLAG_EN
         r_rsp_zero   <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_gnt_id <= w_gnt_id;
            r_op     <= w_gnt_id ? bus.req1_op : bus.req0_op;
            r_a      <= w_gnt_id ? bus.req1_a  : bus.req0_a;
            r_b      <= w_gnt_id ? bus.req1_b  : bus.req0_b;
         end
         if (w_exec) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt_id;
            r_rsp_data  <= w_alu_s;
`ifdef ALU_ZERO_FLAG_EN
            r_rsp_zero  <= (w_alu_s == 4'd0);
`endif
         end
         if (w_rsp_hs) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_rsp_id;
         end
      end
   end

   // Readies and busy are forced low while reset is held, even before the edge.
   assign bus.req0_ready = w_ready0 & rst_n;
   assign bus.req1_ready = w_ready1 & rst_n;
   assign bus.busy       = (r_state != IDLE) & rst_n;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_data   = r_rsp_data;
`ifdef ALU_ZERO_FLAG_EN
   assign bus.rsp_zero   = r_rsp_zero;
`endif
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-004 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: operation accepted this cycle.
REQ-005 The block SHALL have ports req0_op / req1_op, input, 3 bits each: ALU control {L,M,N}.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 4 bits each: operands.
REQ-007 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-008 The block SHALL have port rsp_ready, input, 1 bit: consumer takes result.
REQ-009 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-010 The block SHALL have port rsp_data, output, 4 bits: ALU result S.
REQ-011 The block SHALL have port rsp_zero, output, 1 bit: rsp_data == 0 (present only under ALU_ZERO_FLAG_EN).
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL contain exactly one instance of the team's 4-bit ALU (ports S, A, B, L, M, N) and SHALL drive it only from internal operand/op registers.
REQ-014 The op encoding SHALL be: 000 -A, 001 -B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 low nibble of A*B, 111 A^B; all arithmetic is mod 16 with carry discarded.
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester, assert only that reqN_ready combinationally in the same cycle, capture op/a/b and the grant id, and move to EXEC.
REQ-017 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; a last_grant register resets to 1, so requester 0 wins the first tie.
REQ-018 A lone valid requester SHALL be granted regardless of last_grant.
REQ-019 In EXEC (one cycle), the block SHALL register ALU output S into rsp_data (and rsp_zero), set rsp_valid, and move to RESP.
REQ-020 In RESP, rsp_valid, rsp_id, rsp_data and rsp_zero SHALL hold stable until rsp_valid && rsp_ready; on that handshake the block SHALL clear rsp_valid, update last_grant and return to IDLE.
REQ-021 Both reqN_ready outputs SHALL be low in EXEC and RESP; a request held valid is not lost and is arbitrated again on return to IDLE.
REQ-022 Latency SHALL be: accept in cycle T, rsp_valid high from cycle T+2; peak throughput SHALL be one operation per 3 cycles.
REQ-023 Operand and op registers SHALL NOT change outside the IDLE accept cycle.

Reset
REQ-024 While rst_n is low at a clock edge, the block SHALL go to IDLE and clear rsp_valid, rsp_id, rsp_data, rsp_zero and operand registers; last_grant SHALL be set to 1.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without any response.
REQ-026 Both reqN_ready outputs and busy SHALL be 0 during reset.

Configuration
REQ-027 With macro ALU_ZERO_FLAG_EN defined, port rsp_zero and its register SHALL exist and be set in EXEC to (S == 4'b0000).
REQ-028 Without ALU_ZERO_FLAG_EN, port rsp_zero and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Single request: req0 op=010, a=3, b=5 -> req0_ready in the accept cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=8.
REQ-030 Tie: both requesters valid from reset, req0 op=100 a=12 b=10, req1 op=111 a=12 b=10 -> first rsp_id=0, data=8; second rsp_id=1, data=6.
REQ-031 Wrap/overflow: req1 op=110, a=3, b=6 -> rsp_data=2; req1 op=000, a=1 -> rsp_data=15.
REQ-032 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_* stable, both readies low, busy=1; rsp_ready pulse -> IDLE next cycle.
REQ-033 Reset mid-op: rst_n low during EXEC -> next cycle rsp_valid=0, busy=0, no response issued; the first tie after reset is granted to req0.
REQ-034 Zero flag (ALU_ZERO_FLAG_EN): op=011, a=5, b=5 -> rsp_data=0, rsp_zero=1; a=6, b=5 -> rsp_data=1, rsp_zero=0.
